// File: rtl/aes_bus_pkg.sv
// Shared definitions for the AES register-bus master.
// Contents:
//   state_t    - job sequencing states
//   W_*        - word indices in the AES register map (byte address = base + 4*index)
//   key_base() - first word index of the key slot chosen by a 2-bit key select
package aes_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WKEY,
    WSEL,
    WPT,
    WSTART,
    WCLR,
    POLL,
    RDCT,
    RESP
  } state_t;

  localparam logic [5:0] W_START    = 6'd0;
  localparam logic [5:0] W_PT0      = 6'd1;
  localparam logic [5:0] W_KEY_S0   = 6'd5;
  localparam logic [5:0] W_CT_VALID = 6'd11;
  localparam logic [5:0] W_CT0      = 6'd12;
  localparam logic [5:0] W_KEY_S1   = 6'd20;
  localparam logic [5:0] W_KEY_S2   = 6'd26;
  localparam logic [5:0] W_KEY_SEL  = 6'd32;

  // Select values 2 and 3 both address slot 2.
  function automatic logic [5:0] key_base(input logic [1:0] sel);
    case (sel)
      2'd0:    key_base = W_KEY_S0;
      2'd1:    key_base = W_KEY_S1;
      default: key_base = W_KEY_S2;
    endcase
  endfunction

endpackage

// File: rtl/reg_bus_beat.sv
// Single-beat REG_BUS initiator.
// Ports:
//   clk_i, rst_ni         - clock, synchronous active-low reset
//   start                 - launch a beat (ignored while one is in flight)
//   addr, write, wdata    - beat request, captured on start
//   done                  - beat completes this cycle (valid & ready)
//   rdata, err            - read data / bus error, meaningful while done=1
//   bus_*                 - REG_BUS initiator pins
// Request fields are registered at launch so they stay stable until ready.
// Valid drops on the completing edge, which forces an idle cycle between beats.
module reg_bus_beat (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] bus_addr_o,
  output logic        bus_write_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  output logic        bus_valid_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i,
  input  logic        bus_error_i
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus_valid_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_write_o <= 1'b0;
      bus_wdata_o <= '0;
    end else if (bus_valid_o) begin
      if (bus_ready_i) bus_valid_o <= 1'b0;
    end else if (start) begin
      bus_valid_o <= 1'b1;
      bus_addr_o  <= addr;
      bus_write_o <= write;
      bus_wdata_o <= wdata;
    end
  end

  assign bus_wstrb_o = bus_write_o ? 4'hF : 4'h0;
  assign done        = bus_valid_o & bus_ready_i;
  assign err         = done & bus_error_i;
  assign rdata       = bus_rdata_i;

endmodule

// File: rtl/aes_bus_master.sv
// Drives one AES-192 encryption job through the AES register map over REG_BUS:
// optional key load, key select, plaintext, start pulse, ct_valid polling,
// ciphertext readback, then a response handshake.
// Ports:
//   clk_i, rst_ni                     - clock, synchronous active-low reset
//   req_valid_i/req_ready_o           - job handshake (ready only in IDLE)
//   pt_i, key_i, key_sel_i, key_load_i - job inputs, latched on acceptance
//   rsp_valid_o/rsp_ready_i           - result handshake
//   ct_o, rsp_err_o                   - ciphertext (0 on error), error flag
//   bus_*                             - REG_BUS initiator pins
module aes_bus_master
  import aes_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          POLL_LIMIT = 1024,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [127:0]            pt_i,
  input  logic [191:0]            key_i,
  input  logic [1:0]              key_sel_i,
  input  logic                    key_load_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [127:0]            ct_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic                    bus_write_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [3:0]              bus_wstrb_o,
  output logic                    bus_valid_o,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_ready_i,
  input  logic                    bus_error_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_t         state, state_next;
  logic [127:0]   pt_q;
  logic [191:0]   key_q;
  logic [1:0]     sel_q;
  logic [127:0]   ct_q;
  logic           err_q;
  logic [2:0]     cnt_q;
  logic [PW-1:0]  poll_q;

  logic [5:0]     word;
  logic           beat_write;
  logic [31:0]    beat_wdata;
  logic [31:0]    beat_addr;
  logic           beat_start;
  logic           beat_done;
  logic           beat_err;
  logic [31:0]    beat_rdata;
  logic           poll_timeout;

  function automatic logic [31:0] key_word(input logic [191:0] key, input logic [2:0] idx);
    case (idx)
      3'd0:    key_word = key[31:0];
      3'd1:    key_word = key[63:32];
      3'd2:    key_word = key[95:64];
      3'd3:    key_word = key[127:96];
      3'd4:    key_word = key[159:128];
      3'd5:    key_word = key[191:160];
      default: key_word = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    word         = W_START;
    beat_write   = 1'b1;
    beat_wdata   = '0;
    poll_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) state_next = key_load_i ? WKEY : WSEL;
      end
      WKEY: begin
        word       = key_base(sel_q) + {3'b0, cnt_q};
        beat_wdata = key_word(key_q, cnt_q);
        if (beat_done && cnt_q == 3'd5) state_next = WSEL;
      end
      WSEL: begin
        word       = W_KEY_SEL;
        beat_wdata = {30'b0, sel_q};
        if (beat_done) state_next = WPT;
      end
      WPT: begin
        word       = W_PT0 + {3'b0, cnt_q};
        beat_wdata = pt_q[{cnt_q[1:0], 5'b0} +: 32];
        if (beat_done && cnt_q == 3'd3) state_next = WSTART;
      end
      WSTART: begin
        beat_wdata = 32'd1;
        if (beat_done) state_next = WCLR;
      end
      WCLR: begin
        if (beat_done) state_next = POLL;
      end
      POLL: begin
        word       = W_CT_VALID;
        beat_write = 1'b0;
        if (beat_done) begin
          if (beat_rdata[0]) begin
            state_next = RDCT;
          end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
            // This was the last permitted status read.
            poll_timeout = 1'b1;
            state_next   = RESP;
          end
        end
      end
      RDCT: begin
        word       = W_CT0 + {3'b0, cnt_q};
        beat_write = 1'b0;
        if (beat_done && cnt_q == 3'd3) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A bus error on any beat abandons the job.
    if (beat_err) state_next = RESP;
  end

  // Launch a new beat in every bus state once the previous beat has retired.
  assign beat_start = (state != IDLE) && (state != RESP) && !bus_valid_o;
  assign beat_addr  = BASE_ADDR + {24'b0, word, 2'b00};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pt_q   <= '0;
      key_q  <= '0;
      sel_q  <= '0;
      ct_q   <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      poll_q <= '0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        pt_q  <= pt_i;
        key_q <= key_i;
        sel_q <= key_sel_i;
        ct_q  <= '0;
        err_q <= 1'b0;
      end
      if (state == RDCT && beat_done && !beat_err)
        ct_q[{cnt_q[1:0], 5'b0} +: 32] <= beat_rdata;
      if (beat_err || poll_timeout) begin
        err_q <= 1'b1;
        ct_q  <= '0;
      end
      if (state_next != state) begin
        cnt_q  <= '0;
        poll_q <= '0;
      end else if (beat_done) begin
        if (state == POLL) begin
          if (poll_q != PW'(POLL_LIMIT)) poll_q <= poll_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign ct_o        = ct_q;
  assign rsp_err_o   = err_q;

  reg_bus_beat u_beat (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start       (beat_start),
    .addr        (beat_addr),
    .write       (beat_write),
    .wdata       (beat_wdata),
    .done        (beat_done),
    .rdata       (beat_rdata),
    .err         (beat_err),
    .bus_addr_o  (bus_addr_o),
    .bus_write_o (bus_write_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_wstrb_o (bus_wstrb_o),
    .bus_valid_o (bus_valid_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ready_i (bus_ready_i),
    .bus_error_i (bus_error_i)
  );

endmodule

// File: tb/tb_aes_bus_master.sv
// Directed bench for aes_bus_master with a behavioural AES register responder.
module tb_aes_bus_master;

  localparam logic [31:0]  BASE    = 32'h0001_0000;
  localparam logic [127:0] CT_REF  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] PT_REF  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] KEY_REF = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         req_valid_i, req_ready_o;
  logic [127:0] pt_i;
  logic [191:0] key_i;
  logic [1:0]   key_sel_i;
  logic         key_load_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [127:0] ct_o;
  logic         rsp_err_o;
  logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic         bus_write_o, bus_valid_o, bus_ready_i, bus_error_i;
  logic [3:0]   bus_wstrb_o;

  aes_bus_master #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .pt_i(pt_i), .key_i(key_i), .key_sel_i(key_sel_i), .key_load_i(key_load_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .ct_o(ct_o), .rsp_err_o(rsp_err_o),
    .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_valid_o(bus_valid_o),
    .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i), .bus_error_i(bus_error_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder configuration and beat log
  int          rdy_delay = 0;
  int          ctv_after = 0;   // poll number that first returns ct_valid=1; 0 = never
  int          err_beat  = 0;   // beat number (1-based) answered with error; 0 = none
  int          nbeats, polls, stab_err, gap_err, strb_err;
  logic [31:0] log_addr  [64];
  logic        log_we    [64];
  logic [31:0] log_wdata [64];

  initial begin
    logic        in_beat, just_done;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;
    logic [127:0] ct_tmp;
    int          wait_cnt, idx;
    in_beat = 0; just_done = 0; wait_cnt = 0;
    hold_addr = 0; hold_wdata = 0; hold_we = 0;
    ct_tmp = CT_REF;
    bus_ready_i = 0; bus_error_i = 0; bus_rdata_i = 0;
    forever begin
      @(negedge clk);
      bus_ready_i = 0; bus_error_i = 0; bus_rdata_i = 0;
      if (just_done && bus_valid_o) gap_err++;
      just_done = 0;
      if (bus_valid_o) begin
        if (!in_beat) begin
          in_beat = 1; wait_cnt = 0;
          hold_addr = bus_addr_o; hold_we = bus_write_o; hold_wdata = bus_wdata_o;
        end else if (bus_addr_o !== hold_addr || bus_write_o !== hold_we ||
                     bus_wdata_o !== hold_wdata) begin
          stab_err++;
        end
        if (bus_wstrb_o !== (bus_write_o ? 4'hF : 4'h0)) strb_err++;
        if (wait_cnt >= rdy_delay) begin
          idx = int'((bus_addr_o - BASE) >> 2);
          if (nbeats < 64) begin
            log_addr[nbeats] = bus_addr_o;
            log_we[nbeats]   = bus_write_o;
            log_wdata[nbeats] = bus_wdata_o;
          end
          nbeats++;
          if (!bus_write_o) begin
            if (idx == 11) begin
              polls++;
              bus_rdata_i = 32'hA5A5_A5A4 |
                            {31'b0, (ctv_after != 0 && polls >= ctv_after)};
            end else if (idx >= 12 && idx <= 15) begin
              bus_rdata_i = ct_tmp[(idx - 12) * 32 +: 32];
            end
          end
          if (nbeats == err_beat) bus_error_i = 1;
          bus_ready_i = 1;
          in_beat = 0; just_done = 1;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_beat = 0;
      end
    end
  end

  task automatic clear_log();
    nbeats = 0; polls = 0; stab_err = 0; gap_err = 0; strb_err = 0;
  endtask

  task automatic start_job(input logic kl, input logic [1:0] sel);
    int i;
    i = 0;
    while (!req_ready_o && i < 20) begin @(negedge clk); i++; end
    check("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1; key_load_i = kl; key_sel_i = sel; pt_i = PT_REF; key_i = KEY_REF;
    @(negedge clk);
    check("req_ready_busy", req_ready_o, 1'b0);
    // Keep requesting with different data while busy; it must be ignored.
    pt_i = ~PT_REF; key_i = ~KEY_REF; key_sel_i = ~sel; key_load_i = ~kl;
    repeat (3) @(negedge clk);
    req_valid_i = 0;
  endtask

  task automatic wait_rsp(input string tag);
    int i;
    i = 0;
    while (!rsp_valid_o && i < 400) begin @(negedge clk); i++; end
    check(tag, rsp_valid_o, 1'b1);
  endtask

  task automatic finish_rsp();
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    check("rsp_closed", {rsp_valid_o, req_ready_o}, 2'b01);
  endtask

  function automatic int count_writes();
    int n = 0;
    for (int k = 0; k < nbeats && k < 64; k++) if (log_we[k]) n++;
    return n;
  endfunction

  function automatic int count_reads(input int lo, input int hi);
    int n = 0;
    for (int k = 0; k < nbeats && k < 64; k++)
      if (!log_we[k] && log_addr[k] >= BASE + 32'(lo * 4) && log_addr[k] <= BASE + 32'(hi * 4)) n++;
    return n;
  endfunction

  int          t1_word [20] = '{5, 6, 7, 8, 9, 10, 32, 1, 2, 3, 4, 0, 0, 11, 11, 11, 12, 13, 14, 15};
  logic [31:0] t1_wd   [13] = '{32'h14151617, 32'h10111213, 32'h0c0d0e0f, 32'h08090a0b,
                                32'h04050607, 32'h00010203, 32'h00000000, 32'hccddeeff,
                                32'h8899aabb, 32'h44556677, 32'h00112233, 32'h00000001,
                                32'h00000000};

  initial begin
    int i;
    logic        ew;
    logic [31:0] ed;
    rst_ni = 0; req_valid_i = 0; pt_i = 0; key_i = 0; key_sel_i = 0; key_load_i = 0;
    rsp_ready_i = 0;
    clear_log();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready_o, rsp_valid_o, bus_valid_o, rsp_err_o, bus_write_o,
                            bus_wstrb_o}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    check("reset_ct", ct_o, 128'h0);
    check("reset_addr", bus_addr_o, 32'h0);
    rst_ni = 1;
    @(negedge clk);

    // T1: full job with key load, slot 0, ct_valid on third poll
    clear_log(); rdy_delay = 0; ctv_after = 3; err_beat = 0;
    start_job(1'b1, 2'd0);
    wait_rsp("t1_rsp");
    check("t1_nbeats", nbeats, 20);
    for (int k = 0; k < 20; k++) begin
      ew = (k < 13);
      ed = (k < 13) ? t1_wd[k] : 32'h0;
      check($sformatf("t1_beat%0d", k),
            {log_addr[k], log_we[k], log_we[k] ? log_wdata[k] : 32'h0},
            {BASE + 32'(t1_word[k] * 4), ew, ed});
    end
    check("t1_polls", polls, 3);
    check("t1_ct", ct_o, CT_REF);
    check("t1_err", rsp_err_o, 1'b0);
    check("t1_protocol", {stab_err, gap_err, strb_err}, 96'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t1_hold%0d", k), {rsp_valid_o, ct_o, rsp_err_o}, {1'b1, CT_REF, 1'b0});
    end
    finish_rsp();

    // T2: no key load, select 3, slow responder
    clear_log(); rdy_delay = 2; ctv_after = 1; err_beat = 0;
    start_job(1'b0, 2'd3);
    wait_rsp("t2_rsp");
    check("t2_first", {log_addr[0], log_we[0], log_wdata[0]}, {BASE + 32'd128, 1'b1, 32'd3});
    check("t2_second", {log_addr[1], log_wdata[1]}, {BASE + 32'd4, 32'hccddeeff});
    check("t2_writes", count_writes(), 7);
    check("t2_nbeats", nbeats, 12);
    check("t2_ct_err", {ct_o, rsp_err_o}, {CT_REF, 1'b0});
    check("t2_protocol", {stab_err, gap_err, strb_err}, 96'h0);
    finish_rsp();

    // T3: ct_valid never set, poll limit 4
    clear_log(); rdy_delay = 0; ctv_after = 0; err_beat = 0;
    start_job(1'b0, 2'd1);
    wait_rsp("t3_rsp");
    check("t3_polls", count_reads(11, 11), 4);
    check("t3_ct_reads", count_reads(12, 15), 0);
    check("t3_nbeats", nbeats, 11);
    check("t3_ct_err", {ct_o, rsp_err_o}, {128'h0, 1'b1});
    finish_rsp();

    // T4: bus error on second plaintext write, ready delayed 5 cycles
    clear_log(); rdy_delay = 5; ctv_after = 1; err_beat = 9;
    start_job(1'b1, 2'd1);
    wait_rsp("t4_rsp");
    repeat (10) @(negedge clk);
    check("t4_key_slot1", {log_addr[0], log_wdata[0]}, {BASE + 32'd80, 32'h14151617});
    check("t4_last_beat", {log_addr[8], log_wdata[8]}, {BASE + 32'd8, 32'h8899aabb});
    check("t4_nbeats", nbeats, 9);
    check("t4_idle_bus", bus_valid_o, 1'b0);
    check("t4_ct_err", {rsp_valid_o, ct_o, rsp_err_o}, {1'b1, 128'h0, 1'b1});
    check("t4_stable", {stab_err, gap_err, strb_err}, 96'h0);
    finish_rsp();

    // T5: bus error on second ciphertext read discards partial result
    clear_log(); rdy_delay = 1; ctv_after = 1; err_beat = 10;
    start_job(1'b0, 2'd2);
    wait_rsp("t5_rsp");
    check("t5_sel_write", {log_addr[0], log_wdata[0]}, {BASE + 32'd128, 32'd2});
    check("t5_nbeats", nbeats, 10);
    check("t5_ct_err", {ct_o, rsp_err_o}, {128'h0, 1'b1});
    finish_rsp();

    // T6: reset while polling, then a normal job
    clear_log(); rdy_delay = 3; ctv_after = 0; err_beat = 0;
    start_job(1'b0, 2'd0);
    i = 0;
    while (!(bus_valid_o && bus_addr_o == BASE + 32'd44) && i < 200) begin @(negedge clk); i++; end
    check("t6_in_poll", {bus_valid_o, bus_addr_o}, {1'b1, BASE + 32'd44});
    rst_ni = 0;
    @(negedge clk);
    check("t6_reset_bus", {bus_valid_o, req_ready_o, rsp_valid_o}, 3'b010);
    rst_ni = 1;
    @(negedge clk);
    clear_log(); rdy_delay = 0; ctv_after = 2;
    start_job(1'b1, 2'd0);
    wait_rsp("t6_rsp");
    check("t6_nbeats", nbeats, 19);
    check("t6_ct_err", {ct_o, rsp_err_o}, {CT_REF, 1'b0});
    finish_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
